// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: widths, special register
// addresses and the encodings of the write-destination select.
package register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  // Write-destination select; 2'b11 is reserved and writes nowhere.
  typedef enum logic [1:0] {
    REGDST_RA   = 2'b00,
    REGDST_RT   = 2'b01,
    REGDST_RD   = 2'b10,
    REGDST_RSVD = 2'b11
  } reg_dst_e;

endpackage

// File: rtl/register_file_if.sv
// Bus between decode/writeback logic and the register file.
// There is no valid/ready handshake: reads are combinational and a write
// happens on every rising edge where RegWre is high and the selected
// destination is not $0.
interface register_file_if;
  import register_file_pkg::*;

  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] WriteData;
  logic [1:0]        RegDst;
  logic              RegWre;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] WriteReg;

  modport master (
    output ReadReg1, ReadReg2, rd, WriteData, RegDst, RegWre,
    input  ReadData1, ReadData2, WriteReg
  );

  modport slave (
    input  ReadReg1, ReadReg2, rd, WriteData, RegDst, RegWre,
    output ReadData1, ReadData2, WriteReg
  );

endinterface

// File: rtl/register_file_reg_dst_mux.sv
// Picks the write destination: $ra for jal, rt for I-type, rd for R-type.
// The reserved select maps to $0 so that the write is discarded.
module register_file_reg_dst_mux
  import register_file_pkg::*;
(
  input  logic [1:0]        regDst,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  output logic [ADDR_W-1:0] wa
);

  // Combinational destination select with $0 as the safe fallback.
  always_comb begin
    wa = REG_ZERO;
    case (reg_dst_e'(regDst))
      REGDST_RA: wa = REG_RA;
      REGDST_RT: wa = rt;
      REGDST_RD: wa = rd;
      default:   wa = REG_ZERO;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read
// ports, one synchronous write port, $0 hardwired to zero. Reads see the
// old value during a same-cycle write; there is no write-to-read bypass.
module register_file
  import register_file_pkg::*;
(
  input  logic           CLK,
  input  logic           Reset,
  register_file_if.slave bus
);

  logic [DATA_W-1:0] regs [0:NUM_REGS-1];
  logic [ADDR_W-1:0] writeAddr;

  register_file_reg_dst_mux u_reg_dst_mux (
    .regDst (bus.RegDst),
    .rt     (bus.ReadReg2),
    .rd     (bus.rd),
    .wa     (writeAddr)
  );

  // Storage update: reset clears everything and wins over a write;
  // writes aimed at $0 are dropped so $0 stays zero.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.RegWre && (writeAddr != REG_ZERO)) begin
      regs[writeAddr] <= bus.WriteData;
    end
  end

  assign bus.ReadData1 = (bus.ReadReg1 == REG_ZERO) ? '0 : regs[bus.ReadReg1];
  assign bus.ReadData2 = (bus.ReadReg2 == REG_ZERO) ? '0 : regs[bus.ReadReg2];
  assign bus.WriteReg  = {{(DATA_W-ADDR_W){1'b0}}, writeAddr};

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: reset sweep, directed vector table,
// read-during-write and reset-with-write sequences, then random traffic
// checked against an array model of the architectural registers.
module tb_register_file;
  import register_file_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  register_file_if rfIf ();

  register_file dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (rfIf.slave)
  );

  int checks = 0;
  int failures = 0;

  // Architectural model: what each register should hold
  logic [31:0] model [32];

  typedef struct {
    logic [1:0]  regDst;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        wre;
    logic [4:0]  chkAddr;
    logic [31:0] expData;
    logic [31:0] expWriteReg;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] modelWa(input logic [1:0] rdst, input logic [4:0] rt,
                                         input logic [4:0] rdf);
    case (rdst)
      2'b00:   return 5'd31;
      2'b01:   return rt;
      2'b10:   return rdf;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] addr);
    return (addr == 5'd0) ? 32'd0 : model[addr];
  endfunction

  // Driver
  task automatic drive(input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] rdf,
                       input logic [31:0] wd, input logic [1:0] rdst, input logic wre);
    rfIf.ReadReg1  = rr1;
    rfIf.ReadReg2  = rr2;
    rfIf.rd        = rdf;
    rfIf.WriteData = wd;
    rfIf.RegDst    = rdst;
    rfIf.RegWre    = wre;
  endtask

  // One rising edge; the model commits what the driven inputs ask for.
  task automatic clockEdge();
    logic [4:0] wa;
    @(posedge clk);
    wa = modelWa(rfIf.RegDst, rfIf.ReadReg2, rfIf.rd);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (rfIf.RegWre === 1'b1 && wa != 5'd0) begin
      model[wa] = rfIf.WriteData;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    vecs[0] = '{2'b10, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF, 32'd5};
    vecs[1] = '{2'b01, 5'd7, 5'd0, 32'h00001234, 1'b1, 5'd7,  32'h00001234, 32'd7};
    vecs[2] = '{2'b00, 5'd3, 5'd4, 32'h00000040, 1'b1, 5'd31, 32'h00000040, 32'd31};
    vecs[3] = '{2'b10, 5'd3, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0,  32'h00000000, 32'd0};
    vecs[4] = '{2'b10, 5'd3, 5'd5, 32'h00000001, 1'b0, 5'd5,  32'hDEADBEEF, 32'd5};
    vecs[5] = '{2'b11, 5'd8, 5'd6, 32'h00000077, 1'b1, 5'd6,  32'h00000000, 32'd0};
    vecs[6] = '{2'b01, 5'd0, 5'd9, 32'h00000055, 1'b1, 5'd0,  32'h00000000, 32'd0};

    // Reset for one edge, then every address reads zero
    drive(5'd0, 5'd0, 5'd0, 32'd0, 2'b11, 1'b0);
    @(negedge clk);
    clockEdge();
    reset = 1'b0;
    #1;
    check("reset_writereg_rsvd", rfIf.WriteReg, 32'd0);
    for (int a = 0; a < 32; a++) begin
      rfIf.ReadReg1 = 5'(a);
      rfIf.ReadReg2 = 5'(31 - a);
      #1;
      check("reset_rd1", rfIf.ReadData1, 32'd0);
      check("reset_rd2", rfIf.ReadData2, 32'd0);
    end

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      drive(5'd0, vecs[i].rt, vecs[i].rd, vecs[i].wd, vecs[i].regDst, vecs[i].wre);
      #1;
      check("vec_writereg", rfIf.WriteReg, vecs[i].expWriteReg);
      clockEdge();
      drive(vecs[i].chkAddr, vecs[i].chkAddr, 5'd0, 32'd0, 2'b11, 1'b0);
      #1;
      check("vec_rd1", rfIf.ReadData1, vecs[i].expData);
      check("vec_rd2", rfIf.ReadData2, vecs[i].expData);
    end

    // Read-during-write: old value before the edge, new value after
    drive(5'd5, 5'd5, 5'd5, 32'hA5A5A5A5, 2'b10, 1'b1);
    #1;
    check("rdw_before", rfIf.ReadData1, 32'hDEADBEEF);
    clockEdge();
    #1;
    check("rdw_after_rd1", rfIf.ReadData1, 32'hA5A5A5A5);
    check("rdw_after_rd2", rfIf.ReadData2, 32'hA5A5A5A5);

    // Put something in reg9, then reset together with a write to reg9
    drive(5'd0, 5'd0, 5'd9, 32'h00000011, 2'b10, 1'b1);
    clockEdge();
    rfIf.RegWre = 1'b0;
    rfIf.ReadReg1 = 5'd9;
    #1;
    check("pre_reset_reg9", rfIf.ReadData1, 32'h00000011);
    reset = 1'b1;
    drive(5'd9, 5'd31, 5'd9, 32'h00000099, 2'b10, 1'b1);
    clockEdge();
    reset = 1'b0;
    rfIf.RegWre = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rfIf.ReadReg1 = 5'(a);
      rfIf.ReadReg2 = 5'(a);
      #1;
      check("midreset_rd1", rfIf.ReadData1, 32'd0);
      check("midreset_rd2", rfIf.ReadData2, 32'd0);
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      #1;
      check("rand_writereg", rfIf.WriteReg,
            {27'd0, modelWa(rfIf.RegDst, rfIf.ReadReg2, rfIf.rd)});
      check("rand_rd1", rfIf.ReadData1, modelRead(rfIf.ReadReg1));
      check("rand_rd2", rfIf.ReadData2, modelRead(rfIf.ReadReg2));
      clockEdge();
    end
    reset = 1'b0;
    rfIf.RegWre = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rfIf.ReadReg1 = 5'(a);
      rfIf.ReadReg2 = 5'(31 - a);
      #1;
      check("final_rd1", rfIf.ReadData1, modelRead(5'(a)));
      check("final_rd2", rfIf.ReadData2, modelRead(5'(31 - a)));
    end

    // Report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
